// File: rtl/cache_pkg.sv
// Shared cache read-path definitions: geometry constants, payload typedefs
// and the way-select result record that the LRU update logic also consumes.
package cache_pkg;

   localparam int LINE_SIZE_BYTES = 16;
   localparam int WORD_BYTES      = 4;
   localparam int WAYS            = 4;

   localparam int LINE_W = LINE_SIZE_BYTES * 8;
   localparam int WORD_W = WORD_BYTES * 8;
   localparam int WPL    = LINE_SIZE_BYTES / WORD_BYTES;
   localparam int OFF_W  = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [WAY_W-1:0]  way_idx_t;
   typedef logic [OFF_W-1:0]  off_t;

   typedef struct packed {
      line_t    line;
      word_t    word;
      logic     hit;
      way_idx_t way;
      logic     multi_hit;
   } result_t;

endpackage

// File: rtl/way_prio_encoder.sv
// Lowest-index-wins priority encoder for the per-way hit vector.
// The multi-hit flag is only computed when WAY_SELECT_MULTIHIT_CHK_EN is
// defined; otherwise it is tied low and no popcount logic exists.
module way_prio_encoder #(
   parameter int WAYS  = 4,
   parameter int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [WAYS-1:0]  i_sel,
   output logic             o_any,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_multi
);

   assign o_any = |i_sel;

   // Walk from the top way down so the lowest set bit is the last writer.
   always_comb begin
      o_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (i_sel[i]) begin
            o_idx = IDX_W'(i);
         end
      end
   end

`ifdef WAY_SELECT_MULTIHIT_CHK_EN
   // Count hits; more than one means the tag array holds duplicate tags.
   always_comb begin
      int w_count;
      w_count = 0;
      for (int i = 0; i < WAYS; i++) begin
         w_count = w_count + int'(i_sel[i]);
      end
      o_multi = (w_count > 1);
   end
`else
   assign o_multi = 1'b0;
`endif

endmodule

// File: rtl/way_select_pipe.sv
// Registered way-select stage of the set-associative cache read path.
// Picks the hitting way's line, extracts the addressed word and presents the
// result behind a valid/ready handshake with an output register + skid entry.
// Optional macro WAY_SELECT_MULTIHIT_CHK_EN: registers a multi-hit flag with
// each result and adds a simulation check against accepted multi-hits.
module way_select_pipe
   import cache_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [LINE_W-1:0] i_data [WAYS],
   input  logic [WAYS-1:0]   i_sel,
   input  logic [OFF_W-1:0]  i_offset,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [LINE_W-1:0] o_line,
   output logic [WORD_W-1:0] o_word,
   output logic              o_hit,
   output logic [WAY_W-1:0]  o_way,
   output logic              o_multi_hit
);

   logic     w_any;
   way_idx_t w_idx;
   logic     w_multi;
   line_t    w_line;
   word_t    w_word;
   result_t  w_next;
   logic     w_push;
   logic     w_pop;

   result_t  r_out;
   result_t  r_skid;
   logic     r_outValid;
   logic     r_skidFull;

   way_prio_encoder #(
      .WAYS  (WAYS),
      .IDX_W (WAY_W)
   ) u_prioEnc (
      .i_sel   (i_sel),
      .o_any   (w_any),
      .o_idx   (w_idx),
      .o_multi (w_multi)
   );

   // A miss returns an all-zero line rather than whatever way 0 holds.
   always_comb begin
      w_line = '0;
      if (w_any) begin
         w_line = i_data[w_idx];
      end
   end

   generate
      if (WPL > 1) begin : g_offsetSel
         assign w_word = w_line[i_offset*WORD_W +: WORD_W];
      end else begin : g_singleWord
         assign w_word = w_line[WORD_W-1:0];
      end
   endgenerate

   assign w_next.line      = w_line;
   assign w_next.word      = w_word;
   assign w_next.hit       = w_any;
   assign w_next.way       = w_idx;
   assign w_next.multi_hit = w_multi;

   assign o_ready = !r_skidFull;
   assign w_push  = i_valid && o_ready;
   assign w_pop   = r_outValid && i_ready;

   // Output register refills from the skid first, then from a new push; a
   // push that arrives while the output is held parks in the skid entry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out      <= '0;
         r_skid     <= '0;
         r_outValid <= 1'b0;
         r_skidFull <= 1'b0;
      end else if (!r_outValid || w_pop) begin
         if (r_skidFull) begin
            r_out      <= r_skid;
            r_outValid <= 1'b1;
            r_skidFull <= 1'b0;
         end else if (w_push) begin
            r_out      <= w_next;
            r_outValid <= 1'b1;
         end else begin
            r_outValid <= 1'b0;
         end
      end else if (w_push) begin
         r_skid     <= w_next;
         r_skidFull <= 1'b1;
      end
   end

   assign o_valid     = r_outValid;
   assign o_line      = r_out.line;
   assign o_word      = r_out.word;
   assign o_hit       = r_out.hit;
   assign o_way       = r_out.way;
   assign o_multi_hit = r_out.multi_hit;

`ifdef WAY_SELECT_MULTIHIT_CHK_EN
`ifndef SYNTHESIS
   a_noMultiHit : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                   w_push |-> !w_multi)
      else $warning("way_select_pipe: multi-way hit accepted, sel=%b", i_sel);
`endif
`endif

endmodule

// File: tb/tb_way_select_pipe.sv
// Scoreboard bench for way_select_pipe: the driver pushes the hand-computed
// result of every accepted request, an independent monitor pops and compares
// whenever a result is transferred, and also checks stall stability.
module tb_way_select_pipe;
   import cache_pkg::*;

`ifdef WAY_SELECT_MULTIHIT_CHK_EN
   localparam logic MULTI_EXP = 1'b1;
`else
   localparam logic MULTI_EXP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           i_valid;
   logic           o_ready;
   line_t          data [WAYS];
   logic [WAYS-1:0] i_sel;
   off_t           i_offset;
   logic           o_valid;
   logic           i_ready;
   line_t          o_line;
   word_t          o_word;
   logic           o_hit;
   way_idx_t       o_way;
   logic           o_multi_hit;

   result_t        expQ [$];
   int             testsRun    = 0;
   int             testsFailed = 0;
   line_t          stdData [WAYS];
   logic           accepted;

   always #5 clk = ~clk;

   way_select_pipe dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (data),
      .i_sel       (i_sel),
      .i_offset    (i_offset),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_line      (o_line),
      .o_word      (o_word),
      .o_hit       (o_hit),
      .o_way       (o_way),
      .o_multi_hit (o_multi_hit)
   );

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                              input logic [LINE_W-1:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One cycle of stimulus, driven just after the rising edge; if the DUT will
   // take it at the next edge, the hand-computed result joins the scoreboard.
   task automatic applyStimulus(input logic valid, input logic [WAYS-1:0] sel,
                                input off_t offset, input logic rdy,
                                input logic expHit, input way_idx_t expWay,
                                input word_t expWord, input logic expMulti,
                                output logic acc);
      result_t e;
      @(posedge clk);
      #1;
      i_valid  = valid;
      i_sel    = sel;
      i_offset = offset;
      i_ready  = rdy;
      acc      = valid && o_ready;
      if (acc) begin
         e.line      = expHit ? data[expWay] : '0;
         e.word      = expWord;
         e.hit       = expHit;
         e.way       = expWay;
         e.multi_hit = expMulti;
         expQ.push_back(e);
      end
   endtask

   task automatic idleCycle();
      logic acc;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, acc);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
         idleCycle();
      end
      idleCycle();
      checkOutput(name, LINE_W'(expQ.size()), '0);
   endtask

   // Monitor: compares every transferred result against the scoreboard and
   // checks that held results do not move during a stall.
   initial begin
      result_t e;
      logic    prevHeld;
      result_t prev;
      prevHeld = 1'b0;
      prev     = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevHeld = 1'b0;
            continue;
         end
         if (prevHeld) begin
            checkOutput("stall_valid", LINE_W'(o_valid), LINE_W'(1'b1));
            checkOutput("stall_line", o_line, prev.line);
            checkOutput("stall_word", LINE_W'(o_word), LINE_W'(prev.word));
            checkOutput("stall_way", LINE_W'(o_way), LINE_W'(prev.way));
         end
         if (o_valid && i_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_output", LINE_W'(1'b1), LINE_W'(1'b0));
            end else begin
               e = expQ.pop_front();
               checkOutput("line", o_line, e.line);
               checkOutput("word", LINE_W'(o_word), LINE_W'(e.word));
               checkOutput("hit", LINE_W'(o_hit), LINE_W'(e.hit));
               checkOutput("way", LINE_W'(o_way), LINE_W'(e.way));
               checkOutput("multi_hit", LINE_W'(o_multi_hit), LINE_W'(e.multi_hit));
            end
         end
         prevHeld       = o_valid && !i_ready;
         prev.line      = o_line;
         prev.word      = o_word;
         prev.way       = o_way;
         prev.hit       = o_hit;
         prev.multi_hit = o_multi_hit;
      end
   end

   typedef struct {
      logic [WAYS-1:0] sel;
      off_t            off;
      logic            hit;
      way_idx_t        way;
      word_t           word;
      logic            multi;
   } vec_t;

   vec_t burst [8];

   initial begin
      for (int w = 0; w < WAYS; w++) begin
         for (int k = 0; k < WPL; k++) begin
            stdData[w][k*WORD_W +: WORD_W] = 32'hA000_0000 + 32'(w * 256 + k);
         end
      end
      burst[0] = '{4'b0001, 2'd0, 1'b1, 2'd0, 32'hA000_0000, 1'b0};
      burst[1] = '{4'b0010, 2'd1, 1'b1, 2'd1, 32'hA000_0101, 1'b0};
      burst[2] = '{4'b1000, 2'd3, 1'b1, 2'd3, 32'hA000_0303, 1'b0};
      burst[3] = '{4'b0100, 2'd0, 1'b1, 2'd2, 32'hA000_0200, 1'b0};
      burst[4] = '{4'b0110, 2'd2, 1'b1, 2'd1, 32'hA000_0102, MULTI_EXP};
      burst[5] = '{4'b1100, 2'd1, 1'b1, 2'd2, 32'hA000_0201, MULTI_EXP};
      burst[6] = '{4'b0000, 2'd3, 1'b0, 2'd0, 32'h0000_0000, 1'b0};
      burst[7] = '{4'b1111, 2'd2, 1'b1, 2'd0, 32'hA000_0002, MULTI_EXP};

      rst_n    = 1'b0;
      i_valid  = 1'b0;
      i_sel    = '0;
      i_offset = '0;
      i_ready  = 1'b1;
      data     = stdData;
      data[2]  = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
      #1;
      checkOutput("reset_valid", LINE_W'(o_valid), '0);
      checkOutput("reset_ready", LINE_W'(o_ready), LINE_W'(1'b1));
      checkOutput("reset_line", o_line, '0);
      #11;
      rst_n = 1'b1;

      // Single hit on way 2, word 2.
      applyStimulus(1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 2'd2, 32'h0000_CCCC, 1'b0, accepted);
      // Miss still produces a response.
      applyStimulus(1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0, accepted);
      drain("drain_t1_t2");
      data = stdData;

      // Multi-hit resolves to the lowest way.
      applyStimulus(1'b1, 4'b1010, 2'd3, 1'b1, 1'b1, 2'd1, 32'hA000_0103, MULTI_EXP, accepted);
      drain("drain_t3");

      // Back-to-back burst at full throughput.
      foreach (burst[i]) begin
         applyStimulus(1'b1, burst[i].sel, burst[i].off, 1'b1, burst[i].hit,
                       burst[i].way, burst[i].word, burst[i].multi, accepted);
         checkOutput("burst_ready", LINE_W'(accepted), LINE_W'(1'b1));
      end
      drain("drain_t4");

      // Stall: first result held, second parks in the skid, third waits.
      applyStimulus(1'b1, 4'b0001, 2'd1, 1'b0, 1'b1, 2'd0, 32'hA000_0001, 1'b0, accepted);
      checkOutput("stall_acc1", LINE_W'(accepted), LINE_W'(1'b1));
      applyStimulus(1'b1, 4'b0010, 2'd2, 1'b0, 1'b1, 2'd1, 32'hA000_0102, 1'b0, accepted);
      checkOutput("stall_acc2", LINE_W'(accepted), LINE_W'(1'b1));
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 4'b1000, 2'd0, 1'b0, 1'b1, 2'd3, 32'hA000_0300, 1'b0, accepted);
         checkOutput("stall_ready_low", LINE_W'(o_ready), '0);
      end
      accepted = 1'b0;
      for (int i = 0; i < 10 && !accepted; i++) begin
         applyStimulus(1'b1, 4'b1000, 2'd0, 1'b1, 1'b1, 2'd3, 32'hA000_0300, 1'b0, accepted);
      end
      checkOutput("stall_third_accepted", LINE_W'(accepted), LINE_W'(1'b1));
      drain("drain_t5");

      // Reset while the skid entry is full drops everything in flight.
      applyStimulus(1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 2'd2, 32'hA000_0201, 1'b0, accepted);
      applyStimulus(1'b1, 4'b1000, 2'd2, 1'b0, 1'b1, 2'd3, 32'hA000_0302, 1'b0, accepted);
      @(posedge clk);
      #2;
      checkOutput("pre_reset_skid_full", LINE_W'(o_ready), '0);
      rst_n   = 1'b0;
      i_valid = 1'b0;
      #1;
      checkOutput("async_reset_valid", LINE_W'(o_valid), '0);
      checkOutput("async_reset_ready", LINE_W'(o_ready), LINE_W'(1'b1));
      checkOutput("async_reset_line", o_line, '0);
      checkOutput("async_reset_word", LINE_W'(o_word), '0);
      checkOutput("async_reset_hit", LINE_W'(o_hit), '0);
      checkOutput("async_reset_way", LINE_W'(o_way), '0);
      checkOutput("async_reset_multi", LINE_W'(o_multi_hit), '0);
      expQ.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b1, 4'b0100, 2'd3, 1'b1, 1'b1, 2'd2, 32'hA000_0203, 1'b0, accepted);
      checkOutput("post_reset_accept", LINE_W'(accepted), LINE_W'(1'b1));
      drain("drain_t6");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
